// File: rtl/dsc_pkg.sv
// Shared definitions for the deterministic stochastic multiplier slice:
// default operand width and the operand sequencer state encoding.
package dsc_pkg;

  localparam int unsigned SNG_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CLEAR   = 2'd1,
    RUN     = 2'd2,
    CAPTURE = 2'd3
  } dsc_seq_state_t;

endpackage

// File: rtl/counter.sv
// Free-running up counter with enable and asynchronous reset; overflow flags
// the enabled cycle on which the count wraps from all-ones back to zero.
module counter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic overflow
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (en) begin
      count <= count + 1'b1;
    end
  end

  assign overflow = en & (&count);

endmodule

// File: rtl/dsc_mul_seq.sv
// Operand sequencer around dsc_mul: accepts an operand pair, clears the
// multiplier, runs one full 2^(2W)-clock period, then buffers the product.
module dsc_mul_seq #(
  parameter int unsigned SNG_WIDTH = dsc_pkg::SNG_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [SNG_WIDTH-1:0]     in_a,
  input  logic [SNG_WIDTH-1:0]     in_b,
  output logic [SNG_WIDTH-1:0]     mul_a,
  output logic [SNG_WIDTH-1:0]     mul_b,
  output logic                     mul_rst,
  output logic                     mul_en,
  input  logic [2*SNG_WIDTH-1:0]   mul_z,
  input  logic                     mul_ov,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [2*SNG_WIDTH-1:0]   out_z,
  output logic                     out_err,
  output logic                     busy
);

  import dsc_pkg::*;

  localparam int unsigned CW = 2 * SNG_WIDTH;

  dsc_seq_state_t state;
  dsc_seq_state_t state_nxt;
  logic           ov_seen;
  logic           run_ovf;
  logic           cap_load;

  assign in_ready = (state == IDLE);
  assign busy     = (state != IDLE);
  assign mul_en   = (state == RUN);
  // Shared by dsc_mul and the run counter so both restart together in CLEAR.
  assign mul_rst  = rst | (state == CLEAR);
  assign cap_load = (state == CAPTURE) & (~out_valid | out_ready);

  counter #(
    .WIDTH (CW)
  ) u_run_cnt (
    .clk      (clk),
    .rst      (mul_rst),
    .en       (mul_en),
    .overflow (run_ovf)
  );

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (in_valid) state_nxt = CLEAR;
      CLEAR:   state_nxt = RUN;
      RUN:     if (run_ovf) state_nxt = CAPTURE;
      CAPTURE: if (cap_load) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      mul_a   <= '0;
      mul_b   <= '0;
      ov_seen <= 1'b0;
    end else begin
      state <= state_nxt;
      if ((state == IDLE) && in_valid) begin
        mul_a <= in_a;
        mul_b <= in_b;
      end
      if (state == CLEAR) begin
        ov_seen <= 1'b0;
      end else if ((state == RUN) && mul_ov) begin
        ov_seen <= 1'b1;
      end
    end
  end

  // A load in the same cycle as a consumer pop keeps out_valid high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_z     <= '0;
      out_err   <= 1'b0;
    end else if (cap_load) begin
      out_valid <= 1'b1;
      out_z     <= mul_z;
      out_err   <= ~ov_seen;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dsc_mul_seq.sv
// Scoreboard bench for dsc_mul_seq driving a behavioural unary-stream
// multiplier; a reduced operand width keeps each full period short.
module tb_dsc_mul_seq;

  localparam int unsigned W  = 4;
  localparam int unsigned CW = 2 * W;
  localparam int unsigned N  = 1 << CW;

  typedef struct {
    logic [CW-1:0] z;
    logic          err;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, in_ready;
  logic [W-1:0]  in_a, in_b, mul_a, mul_b;
  logic          mul_rst, mul_en, mul_ov;
  logic [CW-1:0] mul_z, out_z;
  logic          out_valid, out_ready, out_err, busy;

  always #5 clk = ~clk;

  dsc_mul_seq #(.SNG_WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .mul_a(mul_a), .mul_b(mul_b),
    .mul_rst(mul_rst), .mul_en(mul_en), .mul_z(mul_z), .mul_ov(mul_ov),
    .out_valid(out_valid), .out_ready(out_ready), .out_z(out_z),
    .out_err(out_err), .busy(busy)
  );

  // Behavioural multiplier: over all (i,j) pairs, count those with i<a, j<b.
  logic [CW-1:0] m_cnt, m_z;
  logic          ov_kill;

  always @(posedge clk or posedge mul_rst) begin
    if (mul_rst) begin
      m_cnt <= '0;
      m_z   <= '0;
    end else if (mul_en) begin
      m_cnt <= m_cnt + 1'b1;
      if ((m_cnt[CW-1:W] < mul_a) && (m_cnt[W-1:0] < mul_b)) m_z <= m_z + 1'b1;
    end
  end
  assign mul_z  = m_z;
  assign mul_ov = mul_en & (&m_cnt) & ~ov_kill;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  exp_t          sb[$];
  int            checks = 0;
  int            failures = 0;
  int unsigned   n_push = 0;
  int unsigned   n_out = 0;
  int unsigned   acc_cyc;
  logic [W-1:0]  cur_a = '0, cur_b = '0;
  logic          rand_done;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops the scoreboard on every transfer, checks hold stability.
  logic          prev_hold = 1'b0;
  logic [CW-1:0] prev_z;
  logic          prev_err;
  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst) begin
      prev_hold = 1'b0;
    end else begin
      if (prev_hold) begin
        check("hold_valid", {31'd0, out_valid}, 32'd1);
        check("hold_z", {24'd0, out_z}, {24'd0, prev_z});
        check("hold_err", {31'd0, out_err}, {31'd0, prev_err});
      end
      if (busy) begin
        check("mul_a_stable", {28'd0, mul_a}, {28'd0, cur_a});
        check("mul_b_stable", {28'd0, mul_b}, {28'd0, cur_b});
        check("in_ready_busy", {31'd0, in_ready}, 32'd0);
      end
      if (out_valid && out_ready) begin
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL out_unexpected: got z=%0d with empty scoreboard", out_z);
        end else begin
          e = sb.pop_front();
          n_out++;
          check("out_z", {24'd0, out_z}, {24'd0, e.z});
          check("out_err", {31'd0, out_err}, {31'd0, e.err});
        end
      end
      prev_hold = out_valid && !out_ready;
      prev_z    = out_z;
      prev_err  = out_err;
    end
  end

  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b);
    int unsigned t = 0;
    int          p;
    exp_t        e;
    @(negedge clk);
    in_a = a; in_b = b; in_valid = 1'b1;
    while (!in_ready) begin
      @(negedge clk);
      t++;
      if (t > 4 * N) begin
        checks++; failures++;
        $display("FAIL accept_timeout: in_ready low for %0d cycles, required 1", t);
        in_valid = 1'b0;
        return;
      end
    end
    p = int'(a) * int'(b);
    e.z = p[CW-1:0];
    e.err = ov_kill;
    sb.push_back(e);
    n_push++;
    cur_a = a; cur_b = b;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    acc_cyc = cyc;
  endtask

  task automatic wait_drain();
    int unsigned t = 0;
    while (sb.size() != 0 || busy || out_valid) begin
      @(negedge clk);
      t++;
      if (t > 6 * N) begin
        checks++; failures++;
        $display("FAIL drain_timeout: %0d results pending, required 0", sb.size());
        return;
      end
    end
  endtask

  initial begin : watchdog
    #(60000 * 10);
    $display("FAIL watchdog: simulation exceeded cycle budget");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int unsigned t;
    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0;
    out_ready = 1'b1; ov_kill = 1'b0; rand_done = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_mul_a", {28'd0, mul_a}, 32'd0);
    check("rst_mul_b", {28'd0, mul_b}, 32'd0);
    check("rst_mul_en", {31'd0, mul_en}, 32'd0);
    check("rst_mul_rst", {31'd0, mul_rst}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_z", {24'd0, out_z}, 32'd0);
    check("rst_out_err", {31'd0, out_err}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;

    // Latency: out_valid must appear in cycle N+3, i.e. N+2 edges after accept.
    do_op(4'd0, 4'd12);
    t = 0;
    while (1) begin
      @(posedge clk); #1;
      t++;
      if (out_valid || t > 2 * N) break;
    end
    check("latency_edges", cyc - acc_cyc, N + 2);
    wait_drain();

    do_op(4'd15, 4'd15);
    do_op(4'd8, 4'd2);
    wait_drain();

    // Backpressure: two ops with the consumer stalled.
    @(posedge clk); #1 out_ready = 1'b0;
    do_op(4'd7, 4'd9);
    do_op(4'd13, 4'd11);
    repeat (N + 20) @(negedge clk);
    check("stall_mul_en", {31'd0, mul_en}, 32'd0);
    check("stall_in_ready", {31'd0, in_ready}, 32'd0);
    check("stall_busy", {31'd0, busy}, 32'd1);
    check("stall_out_valid", {31'd0, out_valid}, 32'd1);
    check("stall_out_z", {24'd0, out_z}, 32'd63);
    @(posedge clk); #1 out_ready = 1'b1;
    wait_drain();

    // Reset mid-run discards the in-flight op.
    do_op(4'd9, 4'd7);
    repeat (100) @(negedge clk);
    rst = 1'b1;
    n_push = n_push - sb.size();
    sb.delete();
    #1;
    check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    check("midrst_mul_rst", {31'd0, mul_rst}, 32'd1);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    do_op(4'd3, 4'd5);
    wait_drain();

    // Overflow never seen -> error flag; normal run clears it again.
    ov_kill = 1'b1;
    do_op(4'd6, 4'd9);
    wait_drain();
    ov_kill = 1'b0;
    do_op(4'd10, 4'd10);

    // Junk handshakes while busy must not be accepted.
    for (int i = 0; i < 150; i++) begin
      @(negedge clk);
      in_valid = 1'($urandom_range(0, 1));
      in_a = 4'($urandom);
      in_b = 4'($urandom);
    end
    in_valid = 1'b0;
    wait_drain();

    fork
      begin
        for (int k = 0; k < 10; k++) begin
          do_op(4'($urandom), 4'($urandom));
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk); #1 out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    @(posedge clk); #1 out_ready = 1'b1;
    wait_drain();

    check("out_count", n_out, n_push);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
